// File: rtl/fpu_pkg.sv
// fpu_pkg: shared float-format constants, unpacked operand type and GRS bit positions
package fpu_pkg;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_MANT_W = FP_FRAC_W + 5;
  localparam int GRS_S     = 0;
  localparam int GRS_R     = 1;
  localparam int GRS_G     = 2;
  localparam int HID_BIT   = FP_FRAC_W + 3;
  localparam int CARRY_BIT = FP_FRAC_W + 4;
  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp_unpacked_t;
endpackage

// File: rtl/fp_align_stage_if.sv
// fp_align_stage_if: operand/result handshake bundle for the alignment stage
// slave (the stage): takes in_valid, op_a, op_b, op_sub, out_ready;
//   drives in_ready, out_valid, mant_a, mant_b, aos, res_sign, res_exp, special.
// master (upstream/downstream side): the mirror image.
interface fp_align_stage_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int MANT_W = FRAC_W + 5;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic              op_sub;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] mant_a;
  logic [MANT_W-1:0] mant_b;
  logic              aos;
  logic              res_sign;
  logic [EXP_W-1:0]  res_exp;
  logic              special;
  modport slave (
    input  in_valid, op_a, op_b, op_sub, out_ready,
    output in_ready, out_valid, mant_a, mant_b, aos, res_sign, res_exp, special
  );
  modport master (
    output in_valid, op_a, op_b, op_sub, out_ready,
    input  in_ready, out_valid, mant_a, mant_b, aos, res_sign, res_exp, special
  );
endinterface

// File: rtl/fp_shift_sticky.sv
// fp_shift_sticky: right shifter that folds every shifted-out bit into the sticky LSB
// mant_i: mantissa {carry, hidden, frac, g, r, s}; shamt_i: shift distance; mant_o: shifted result
module fp_shift_sticky #(
  parameter int MANT_W = 28,
  parameter int SH_W   = 8
) (
  input  logic [MANT_W-1:0] mant_i,
  input  logic [SH_W-1:0]   shamt_i,
  output logic [MANT_W-1:0] mant_o
);
  localparam logic [SH_W-1:0] LIM = SH_W'(MANT_W - 1);
  logic [MANT_W-1:0] sh;
  logic              lost;
  always_comb begin
    sh     = mant_i >> shamt_i;
    lost   = |(mant_i & ~({MANT_W{1'b1}} << shamt_i));
    mant_o = shamt_i >= LIM ? {{(MANT_W-1){1'b0}}, |mant_i} : {sh[MANT_W-1:1], sh[0] | lost};
  end
endmodule

// File: rtl/fp_align_stage.sv
// fp_align_stage: two-stage FP add/sub operand alignment (unpack/swap, then shift with sticky)
// clk, rst_n (sync, active-low); bus: fp_align_stage_if.slave handshake/operand/result bundle
// FP_ALIGN_SPECIAL_EN: when defined, an all-ones exponent raises special and zeroes the datapath
module fp_align_stage
  import fpu_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int FRAC_W = FP_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_align_stage_if.slave   bus
);
  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int MANT_W = FRAC_W + 5;
  logic              adv;
  logic              sa, sb, ha, hb, swap, eq, spec;
  logic [EXP_W-1:0]  ea, eb, eea, eeb;
  logic [MANT_W-1:0] ma, mb;
  logic [MANT_W-1:0] big_d, small_d;
  logic [EXP_W-1:0]  exp_d, dist_d;
  logic              aos_d, sign_d;
  logic              s1_v_q, s1_aos_q, s1_sign_q, s1_spec_q;
  logic [MANT_W-1:0] s1_big_q, s1_small_q, shifted;
  logic [EXP_W-1:0]  s1_exp_q, s1_dist_q;
  logic              out_v_q, aos_q, sign_q, spec_q;
  logic [MANT_W-1:0] mant_a_q, mant_b_q;
  logic [EXP_W-1:0]  exp_q;
  // Whole pipeline moves in lockstep, so one advance term covers both stages
  assign adv          = !out_v_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign sa   = bus.op_a[W-1];
  assign sb   = bus.op_b[W-1] ^ bus.op_sub;
  assign ea   = bus.op_a[W-2:FRAC_W];
  assign eb   = bus.op_b[W-2:FRAC_W];
  assign ha   = |ea;
  assign hb   = |eb;
  assign eea  = ha ? ea : EXP_W'(1);
  assign eeb  = hb ? eb : EXP_W'(1);
  assign ma   = {1'b0, ha, bus.op_a[FRAC_W-1:0], 3'b000};
  assign mb   = {1'b0, hb, bus.op_b[FRAC_W-1:0], 3'b000};
  // Raw {exp, frac} order equals magnitude order, denormals included
  assign swap = bus.op_a[W-2:0] < bus.op_b[W-2:0];
  assign eq   = bus.op_a[W-2:0] == bus.op_b[W-2:0];
`ifdef FP_ALIGN_SPECIAL_EN
  assign spec = &ea | &eb;
`else
  assign spec = 1'b0;
`endif
  always_comb begin
    exp_d   = swap ? eeb : eea;
    dist_d  = swap ? eeb - eea : eea - eeb;
    big_d   = spec ? '0 : swap ? mb : ma;
    small_d = spec ? '0 : swap ? ma : mb;
    aos_d   = (sa ^ sb) & !spec;
    // x - x rounds to +0
    sign_d  = (eq && (sa ^ sb)) ? 1'b0 : swap ? sb : sa;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_big_q   <= '0;
      s1_small_q <= '0;
      s1_exp_q   <= '0;
      s1_dist_q  <= '0;
      s1_aos_q   <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_spec_q  <= 1'b0;
    end else if (adv) begin
      s1_v_q     <= bus.in_valid;
      s1_big_q   <= big_d;
      s1_small_q <= small_d;
      s1_exp_q   <= exp_d;
      s1_dist_q  <= dist_d;
      s1_aos_q   <= aos_d;
      s1_sign_q  <= sign_d;
      s1_spec_q  <= spec;
    end
  end
  fp_shift_sticky #(.MANT_W(MANT_W), .SH_W(EXP_W)) u_shift (
    .mant_i  (s1_small_q),
    .shamt_i (s1_dist_q),
    .mant_o  (shifted)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_v_q  <= 1'b0;
      mant_a_q <= '0;
      mant_b_q <= '0;
      exp_q    <= '0;
      aos_q    <= 1'b0;
      sign_q   <= 1'b0;
      spec_q   <= 1'b0;
    end else if (adv) begin
      out_v_q  <= s1_v_q;
      mant_a_q <= s1_big_q;
      mant_b_q <= shifted;
      exp_q    <= s1_exp_q;
      aos_q    <= s1_aos_q;
      sign_q   <= s1_sign_q;
      spec_q   <= s1_spec_q;
    end
  end
  assign bus.out_valid = out_v_q;
  assign bus.mant_a    = mant_a_q;
  assign bus.mant_b    = mant_b_q;
  assign bus.res_exp   = exp_q;
  assign bus.aos       = aos_q;
  assign bus.res_sign  = sign_q;
  assign bus.special   = spec_q;
endmodule

// File: tb/tb_fp_align_stage.sv
// tb_fp_align_stage: directed self-checking bench for fp_align_stage
module tb_fp_align_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  fp_align_stage_if bus ();
  fp_align_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.op_a = 32'h3F800000;
    bus.op_b = 32'h3F800000;
    bus.op_sub = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.mant_a !== 28'h0) begin failures++; $display("FAIL reset mant_a got %h want 0", bus.mant_a); end
    checks++; if (bus.mant_b !== 28'h0) begin failures++; $display("FAIL reset mant_b got %h want 0", bus.mant_b); end
    checks++; if (bus.res_exp !== 8'h0) begin failures++; $display("FAIL reset res_exp got %h want 0", bus.res_exp); end
    checks++; if ({bus.aos, bus.res_sign, bus.special} !== 3'b000) begin failures++; $display("FAIL reset flags got %b want 000", {bus.aos, bus.res_sign, bus.special}); end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset post out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_align(input string name, input logic [31:0] a, input logic [31:0] b, input logic sub,
                            input logic [27:0] xa, input logic [27:0] xb, input logic [7:0] xe,
                            input logic xaos, input logic xsign, input logic xspec);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    bus.op_sub = sub;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL %s in_ready got %b want 1", name, bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL %s early out_valid got %b want 0", name, bus.out_valid); end
    @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL %s out_valid got %b want 1", name, bus.out_valid); end
    checks++; if (bus.mant_a !== xa) begin failures++; $display("FAIL %s mant_a got %h want %h", name, bus.mant_a, xa); end
    checks++; if (bus.mant_b !== xb) begin failures++; $display("FAIL %s mant_b got %h want %h", name, bus.mant_b, xb); end
    checks++; if (bus.res_exp !== xe) begin failures++; $display("FAIL %s res_exp got %0d want %0d", name, bus.res_exp, xe); end
    checks++; if (bus.aos !== xaos) begin failures++; $display("FAIL %s aos got %b want %b", name, bus.aos, xaos); end
    checks++; if (bus.res_sign !== xsign) begin failures++; $display("FAIL %s res_sign got %b want %b", name, bus.res_sign, xsign); end
    checks++; if (bus.special !== xspec) begin failures++; $display("FAIL %s special got %b want %b", name, bus.special, xspec); end
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    int oidx = 0;
    int stalls = 0;
    logic held = 1'b0;
    logic [27:0] ha = '0, hb = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      bus.in_valid = idx < 4;
      bus.op_a = 32'h3F800000;
      bus.op_b = {1'b0, 8'(126 - idx), 23'd0};
      bus.op_sub = 1'b0;
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stalls++;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b stall in_ready got %b want 0", bus.in_ready); end
        if (held) begin
          checks++; if ({bus.mant_a, bus.mant_b} !== {ha, hb}) begin failures++; $display("FAIL b2b hold got %h/%h want %h/%h", bus.mant_a, bus.mant_b, ha, hb); end
        end
        ha = bus.mant_a;
        hb = bus.mant_b;
        held = 1'b1;
      end else held = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (oidx >= 4) begin failures++; $display("FAIL b2b extra result got %h want none", bus.mant_b); end
        else if ({bus.mant_a, bus.mant_b} !== {28'h4000000, 28'h2000000 >> oidx}) begin
          failures++; $display("FAIL b2b result%0d got %h/%h want %h/%h", oidx, bus.mant_a, bus.mant_b, 28'h4000000, 28'h2000000 >> oidx);
        end
        oidx++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (oidx != 4) begin failures++; $display("FAIL b2b count got %0d want 4", oidx); end
    checks++; if (stalls != 3) begin failures++; $display("FAIL b2b stall cycles got %0d want 3", stalls); end
  endtask

  task automatic test_reset_flush;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.op_a = 32'h3F800000;
    bus.op_b = 32'h3F000000;
    bus.op_sub = 1'b0;
    @(negedge clk);
    bus.op_b = 32'h3E800000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush in-flight out_valid got %b want 1", bus.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.mant_b !== 28'h0) begin failures++; $display("FAIL flush mant_b got %h want 0", bus.mant_b); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush stale out_valid cycle %0d got %b want 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_special;
`ifdef FP_ALIGN_SPECIAL_EN
    test_align("inf", 32'h7F800000, 32'h3F800000, 1'b1, 28'h0, 28'h0, 8'd255, 1'b0, 1'b0, 1'b1);
`else
    test_align("inf_plain", 32'h7F800000, 32'h3F800000, 1'b0, 28'h4000000, 28'h0000001, 8'd255, 1'b0, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    test_reset;
    test_align("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 28'h4000000, 28'h4000000, 8'd127, 1'b0, 1'b0, 1'b0);
    test_align("one_minus_half", 32'h3F800000, 32'h3F000000, 1'b1, 28'h4000000, 28'h2000000, 8'd127, 1'b1, 1'b0, 1'b0);
    test_align("swap", 32'h3F000000, 32'hBF800000, 1'b0, 28'h4000000, 28'h2000000, 8'd127, 1'b1, 1'b1, 1'b0);
    test_align("d30", 32'h3F800000, 32'h30800000, 1'b0, 28'h4000000, 28'h0000001, 8'd127, 1'b0, 1'b0, 1'b0);
    test_align("d27", 32'h3F800000, 32'h32000000, 1'b0, 28'h4000000, 28'h0000001, 8'd127, 1'b0, 1'b0, 1'b0);
    test_align("d25_sticky", 32'h3F800000, 32'h33000001, 1'b0, 28'h4000000, 28'h0000003, 8'd127, 1'b0, 1'b0, 1'b0);
    test_align("equal_sub", 32'h3F800000, 32'h3F800000, 1'b1, 28'h4000000, 28'h4000000, 8'd127, 1'b1, 1'b0, 1'b0);
    test_align("neg_equal_sub", 32'hBF800000, 32'hBF800000, 1'b1, 28'h4000000, 28'h4000000, 8'd127, 1'b1, 1'b0, 1'b0);
    test_align("denormal", 32'h00000001, 32'h00800000, 1'b0, 28'h4000000, 28'h0000008, 8'd1, 1'b0, 1'b0, 1'b0);
    test_back_to_back;
    test_reset_flush;
    test_special;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_align_stage.md
FP_ALIGN_STAGE -- requirements
Module: fp_align_stage

Interface
REQ-001 Parameter EXP_W, default 8, exponent width.
REQ-002 Parameter FRAC_W, default 23, fraction width; aligned mantissa width MANT_W = FRAC_W+5 (28 by default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  stage accepts operands this cycle.
REQ-007 op_a, op_b  input  1+EXP_W+FRAC_W each  IEEE-754 operands {sign, exp, frac}.
REQ-008 op_sub  input  1  0 = A+B, 1 = A-B.
REQ-009 out_valid  output  1  aligned result present.
REQ-010 out_ready  input  1  downstream consumes result.
REQ-011 mant_a, mant_b  output  MANT_W each  aligned mantissas, larger magnitude on mant_a; bit layout {carry headroom, hidden, frac, guard, round, sticky}.
REQ-012 aos  output  1  effective subtract, drives adder carry-in/invert control.
REQ-013 res_sign  output  1  sign of result (larger-magnitude operand, op_sub applied to B).
REQ-014 res_exp  output  EXP_W  larger exponent (denormal treated as 1).
REQ-015 special  output  1  NaN/Inf present (see Configuration).

Function
REQ-016 Two pipeline stages; latency exactly 2 cycles from accepted input to out_valid with no stall.
REQ-017 Stage 1 SHALL unpack: hidden bit = (exp != 0); effective exponent = max(exp,1); effective sign of B = sign_b XOR op_sub.
REQ-018 Stage 1 SHALL compare {exp, frac} magnitudes and swap so mant_a >= mant_b in magnitude; ties keep A on mant_a.
REQ-019 aos SHALL equal sign_a XOR effective sign_b.
REQ-020 Stage 2 SHALL right-shift smaller mantissa by d = exp difference; guard/round take shifted-out bits, sticky = OR of all bits below round.
REQ-021 d >= MANT_W-1 SHALL yield mant_b = 0 except sticky = OR of original nonzero mantissa.
REQ-022 Handshake: pipeline advances when !out_valid || out_ready; in_ready SHALL equal that condition combinationally.
REQ-023 A transfer occurs only on in_valid && in_ready; out_valid && !out_ready SHALL hold all outputs stable.
REQ-024 Bubbles SHALL propagate: stage valid bits clear when no input accepted.
REQ-025 Simultaneous accept and output SHALL sustain one result per cycle.
REQ-026 Exact equal magnitudes with aos=1 SHALL give res_sign = 0 (round-to-nearest +0).

Reset
REQ-027 While rst_n = 0 at clk edge: both stage valids, out_valid, mant_a, mant_b, res_exp, aos, res_sign, special SHALL be 0.
REQ-028 Reset mid-operation SHALL discard in-flight data; in_ready SHALL be 1 the cycle after reset deasserts.

Configuration
REQ-029 Macro FP_ALIGN_SPECIAL_EN defined: exp all-ones on either operand sets special=1, mantissas forced 0, aos=0 ahead of the adder.
REQ-030 Macro undefined: special tied 0, all-ones exponents aligned as ordinary numbers, no detection logic.

Structure
REQ-031 Shared package fpu_pkg SHALL hold EXP_W/FRAC_W/MANT_W constants, unpacked-operand struct typedef, GRS bit index constants.
REQ-032 One sub-module fp_shift_sticky (parametric right shifter with sticky collection) SHALL implement REQ-020/021.

Verification
REQ-033 op_a=0x3F800000, op_b=0x3F800000, op_sub=0 -> after 2 cycles mant_a=mant_b=28'h4000000, res_exp=127, aos=0, res_sign=0.
REQ-034 op_a=0x3F800000, op_b=0x3F000000, op_sub=1 -> mant_a=28'h4000000, mant_b=28'h2000000, res_exp=127, aos=1.
REQ-035 op_a=0x3F000000, op_b=0xBF800000, op_sub=0 -> swap: mant_a=28'h4000000, mant_b=28'h2000000, aos=1, res_sign=1.
REQ-036 op_a=0x3F800000, op_b=0x30800000 (d=30) -> mant_b=28'h0000001, mant_a=28'h4000000.
REQ-037 Back-to-back 4 inputs with out_ready low cycles 3-5 -> in_ready low while stalled, outputs held stable, all 4 results in order, none dropped/duplicated.
REQ-038 rst_n low one cycle with 2 results in flight -> out_valid=0 next cycle, no stale result emerges; with FP_ALIGN_SPECIAL_EN, op_a=0x7F800000 -> special=1.
